alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 103 ++++++++++
 tb/tb_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, field positions and function-code constants for alu_sequencer
package alu_seq_pkg;

   localparam int INSTR_W = 10;

   localparam int FUN_MSB = 9;
   localparam int FUN_LSB = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 4;
   localparam int RS1_MSB = 3;
   localparam int RS1_LSB = 2;
   localparam int RS2_MSB = 1;
   localparam int RS2_LSB = 0;

   localparam logic [3:0] FUN_LOW_LAST = 4'b0101;
   localparam logic [3:0] FUN_ADD      = 4'b1000;
   localparam logic [3:0] FUN_SUB      = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Field order matches the instruction word bit positions above.
   typedef struct packed {
      logic [3:0] fun;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
   } instr_t;

   function automatic logic is_legal_fun(input logic [3:0] fun);
      return (fun <= FUN_LOW_LAST) || (fun == FUN_ADD) || (fun == FUN_SUB);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction, load, external ALU and status signals of alu_sequencer
interface alu_sequencer_if;
   import alu_seq_pkg::*;

   logic               in_instr_valid;
   logic [INSTR_W-1:0] in_instr;
   logic               out_instr_ready;
   logic               in_ld_en;
   logic [1:0]         in_ld_addr;
   logic [3:0]         in_ld_data;
   logic [3:0]         out_a;
   logic [3:0]         out_b;
   logic [3:0]         out_fun;
   logic [3:0]         in_alu;
   logic               in_carry;
   logic               out_done;
   logic               out_err;
   logic               out_zero;
   logic               out_cflag;

   modport master (
      output in_instr_valid, in_instr, in_ld_en, in_ld_addr, in_ld_data, in_alu, in_carry,
      input  out_instr_ready, out_a, out_b, out_fun, out_done, out_err, out_zero, out_cflag
   );

   modport slave (
      input  in_instr_valid, in_instr, in_ld_en, in_ld_addr, in_ld_data, in_alu, in_carry,
      output out_instr_ready, out_a, out_b, out_fun, out_done, out_err, out_zero, out_cflag
   );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - 4x4 register file, two read ports, writeback wins over load on the same register
module seq_regfile (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] rd_addr_a,
   input  logic [1:0] rd_addr_b,
   output logic [3:0] rd_data_a,
   output logic [3:0] rd_data_b,
   input  logic       wb_en,
   input  logic [1:0] wb_addr,
   input  logic [3:0] wb_data,
   input  logic       ld_en,
   input  logic [1:0] ld_addr,
   input  logic [3:0] ld_data
);

   logic [3:0] regs [4];

   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];

   // A load to a register other than the writeback target still commits on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wb_en && (wb_addr == 2'(i)))
               regs[i] <= wb_data;
            else if (ld_en && (ld_addr == 2'(i)))
               regs[i] <= ld_data;
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences one instruction through an external ALU: IDLE, EXEC, WB (ERR for reserved codes)
// Status flag flops are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic           in_clk,
   input  logic           in_rst,
   alu_sequencer_if.slave bus
);

   state_t     state;
   state_t     state_nxt;
   instr_t     cur;
   logic       accept;
   logic       wb_en;
   logic [3:0] rd_a;
   logic [3:0] rd_b;

   assign accept = bus.in_instr_valid && (state == IDLE);

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst)      cur <= '0;
      else if (accept) cur <= instr_t'(bus.in_instr);
   end

   always_comb begin
      state_nxt           = state;
      wb_en               = 1'b0;
      bus.out_instr_ready = 1'b0;
      bus.out_a           = 4'd0;
      bus.out_b           = 4'd0;
      bus.out_fun         = 4'd0;
      bus.out_done        = 1'b0;
      bus.out_err         = 1'b0;
      unique case (state)
         IDLE: begin
            bus.out_instr_ready = 1'b1;
            if (bus.in_instr_valid)
               state_nxt = is_legal_fun(bus.in_instr[FUN_MSB:FUN_LSB]) ? EXEC : ERR;
         end
         EXEC: begin
            bus.out_a   = rd_a;
            bus.out_b   = rd_b;
            bus.out_fun = cur.fun;
            wb_en       = 1'b1;
            state_nxt   = WB;
         end
         WB: begin
            bus.out_done = 1'b1;
            state_nxt    = IDLE;
         end
         ERR: begin
            bus.out_done = 1'b1;
            bus.out_err  = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   seq_regfile u_rf (
      .clk       (in_clk),
      .rst       (in_rst),
      .rd_addr_a (cur.rs1),
      .rd_addr_b (cur.rs2),
      .rd_data_a (rd_a),
      .rd_data_b (rd_b),
      .wb_en     (wb_en),
      .wb_addr   (cur.rd),
      .wb_data   (bus.in_alu),
      .ld_en     (bus.in_ld_en),
      .ld_addr   (bus.in_ld_addr),
      .ld_data   (bus.in_ld_data)
   );

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q;
   logic cflag_q;

   // EXEC is only reached by legal codes, so the reserved path never touches the flags.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         zero_q  <= 1'b0;
         cflag_q <= 1'b0;
      end else if (state == EXEC) begin
         zero_q  <= (bus.in_alu == 4'd0);
         cflag_q <= bus.in_carry;
      end
   end

   assign bus.out_zero  = zero_q;
   assign bus.out_cflag = cflag_q;
`else
   assign bus.out_zero  = 1'b0;
   assign bus.out_cflag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a stand-in ALU and a register-file model
module tb_alu_sequencer;

   logic in_clk = 1'b0;
   logic in_rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   alu_sequencer_if bus();

   alu_sequencer dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .bus    (bus)
   );

   always #5 in_clk = ~in_clk;

   logic [3:0] reg_m [4];
   logic       fz_m;
   logic       fc_m;
   logic       force_en  = 1'b0;
   logic [4:0] force_val = 5'd0;

   // Stand-in ALU: result {carry, value} for each legal function code.
   function automatic logic [4:0] alu_ref(input logic [3:0] fun, input logic [3:0] a, input logic [3:0] b);
      case (fun)
         4'd0:    return {1'b0, a & b};
         4'd1:    return {1'b0, a | b};
         4'd2:    return {1'b0, a ^ b};
         4'd3:    return {1'b0, ~a};
         4'd4:    return {a, 1'b0};
         4'd5:    return {a[0], 1'b0, a[3:1]};
         4'd8:    return {1'b0, a} + {1'b0, b};
         4'd9:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
         default: return 5'd0;
      endcase
   endfunction

   always_comb begin
      if (force_en) {bus.in_carry, bus.in_alu} = force_val;
      else          {bus.in_carry, bus.in_alu} = alu_ref(bus.out_fun, bus.out_a, bus.out_b);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), dut.u_rf.regs[i], reg_m[i]);
   endtask

   task automatic check_flags();
`ifdef ALU_SEQ_FLAGS_EN
      chk("zero", bus.out_zero, fz_m);
      chk("cflag", bus.out_cflag, fc_m);
`else
      chk("zero_tied", bus.out_zero, 0);
      chk("cflag_tied", bus.out_cflag, 0);
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.out_instr_ready && n < 10) begin
         @(posedge in_clk); #1;
         n++;
      end
      chk("wait_ready", bus.out_instr_ready, 1);
   endtask

   task automatic load(input logic [1:0] a, input logic [3:0] d);
      bus.in_ld_en = 1'b1; bus.in_ld_addr = a; bus.in_ld_data = d;
      @(posedge in_clk);
      reg_m[a] = d;
      #1 bus.in_ld_en = 1'b0;
   endtask

   // l0 is applied on the acceptance edge, l1 on the following edge.
   task automatic run_instr(input logic [3:0] fun, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic l0e, input logic [1:0] l0a,
                            input logic [3:0] l0d, input logic l1e, input logic [1:0] l1a,
                            input logic [3:0] l1d, output logic saw_err);
      logic [4:0] r;
      logic       legal;
      legal = fun inside {[4'd0:4'd5], 4'd8, 4'd9};
      wait_ready();
      bus.in_instr_valid = 1'b1; bus.in_instr = {fun, rd, rs1, rs2};
      bus.in_ld_en = l0e; bus.in_ld_addr = l0a; bus.in_ld_data = l0d;
      @(posedge in_clk);
      if (l0e) reg_m[l0a] = l0d;
      #1;
      bus.in_instr_valid = 1'b0;
      bus.in_ld_en = l1e; bus.in_ld_addr = l1a; bus.in_ld_data = l1d;
      saw_err = bus.out_err;
      chk("busy_ready", bus.out_instr_ready, 0);
      if (legal) begin
         chk("exec_a", bus.out_a, reg_m[rs1]);
         chk("exec_b", bus.out_b, reg_m[rs2]);
         chk("exec_fun", bus.out_fun, fun);
         chk("exec_done", bus.out_done, 0);
         r = force_en ? force_val : alu_ref(fun, reg_m[rs1], reg_m[rs2]);
         @(posedge in_clk);
         if (l1e && l1a != rd) reg_m[l1a] = l1d;
         reg_m[rd] = r[3:0];
         fz_m = (r[3:0] == 4'd0);
         fc_m = r[4];
         #1 bus.in_ld_en = 1'b0;
         chk("wb_done", bus.out_done, 1);
         chk("wb_err", bus.out_err, 0);
         chk("wb_a", bus.out_a, 0);
         @(posedge in_clk); #1;
         chk("idle_done", bus.out_done, 0);
      end else begin
         chk("err_done", bus.out_done, 1);
         chk("err_err", bus.out_err, 1);
         chk("err_fun", bus.out_fun, 0);
         @(posedge in_clk);
         if (l1e) reg_m[l1a] = l1d;
         #1 bus.in_ld_en = 1'b0;
      end
      chk("ready_again", bus.out_instr_ready, 1);
      check_regs();
      check_flags();
   endtask

   typedef struct {
      logic [3:0] a, b, fun;
      logic [1:0] rd, rs1, rs2;
      logic [3:0] exp_res;
      logic       exp_c, exp_err;
   } vec_t;

   vec_t vt [10];

   initial begin
      logic e;
      int   acc;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e;
      int   acc;
      vt[0] = '{4'h6, 4'h3, 4'd0, 2'd3, 2'd1, 2'd2, 4'h2, 1'b0, 1'b0};
      vt[1] = '{4'h6, 4'h3, 4'd1, 2'd3, 2'd1, 2'd2, 4'h7, 1'b0, 1'b0};
      vt[2] = '{4'h6, 4'h3, 4'd2, 2'd3, 2'd1, 2'd2, 4'h5, 1'b0, 1'b0};
      vt[3] = '{4'h6, 4'h3, 4'd3, 2'd3, 2'd1, 2'd2, 4'h9, 1'b0, 1'b0};
      vt[4] = '{4'h9, 4'h0, 4'd4, 2'd3, 2'd1, 2'd2, 4'h2, 1'b1, 1'b0};
      vt[5] = '{4'h9, 4'h0, 4'd5, 2'd3, 2'd1, 2'd2, 4'h4, 1'b1, 1'b0};
      vt[6] = '{4'hF, 4'h1, 4'd8, 2'd3, 2'd1, 2'd2, 4'h0, 1'b1, 1'b0};
      vt[7] = '{4'h2, 4'h5, 4'd9, 2'd3, 2'd1, 2'd2, 4'hD, 1'b0, 1'b0};
      vt[8] = '{4'h4, 4'h4, 4'd7, 2'd1, 2'd1, 2'd2, 4'h4, 1'b0, 1'b1};
      vt[9] = '{4'hC, 4'h1, 4'd15, 2'd1, 2'd1, 2'd2, 4'hC, 1'b0, 1'b1};

      for (int i = 0; i < 4; i++) reg_m[i] = 4'd0;
      fz_m = 1'b0; fc_m = 1'b0;
      bus.in_instr_valid = 1'b0; bus.in_instr = '0;
      bus.in_ld_en = 1'b0; bus.in_ld_addr = 2'd0; bus.in_ld_data = 4'd0;

      // Reset values, then acceptance on the first edge after release.
      repeat (2) @(posedge in_clk);
      #1;
      chk("rst_ready", bus.out_instr_ready, 1);
      chk("rst_done", bus.out_done, 0);
      chk("rst_err", bus.out_err, 0);
      chk("rst_abf", {bus.out_a, bus.out_b, bus.out_fun}, 0);
      check_regs();
      check_flags();
      in_rst = 1'b0;
      run_instr(4'd1, 2'd3, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, e);

      // Add example: R1=3, R2=5 gives R0=8.
      load(2'd1, 4'd3);
      load(2'd2, 4'd5);
      run_instr(4'd8, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, e);
      chk("add_r0", dut.u_rf.regs[0], 8);

      // Subtract to zero sets zero and carry.
      load(2'd2, 4'd3);
      run_instr(4'd9, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, e);
      chk("sub_r0", dut.u_rf.regs[0], 0);
`ifdef ALU_SEQ_FLAGS_EN
      chk("sub_zero", bus.out_zero, 1);
      chk("sub_cflag", bus.out_cflag, 1);
`endif

      // Reserved code: two cycles, registers and flags untouched.
      run_instr(4'd6, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, e);
      chk("rsv_err_seen", e, 1);

      // Valid held high: ready every third cycle, one acceptance each time.
      wait_ready();
      bus.in_instr_valid = 1'b1; bus.in_instr = {4'd0, 2'd1, 2'd1, 2'd1};
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("hold_ready%0d", i), bus.out_instr_ready, (i % 3 == 0) ? 1 : 0);
         if (bus.out_instr_ready) acc++;
         @(posedge in_clk); #1;
      end
      bus.in_instr_valid = 1'b0;
      chk("hold_accepts", acc, 3);
      check_regs();

      // Load visible on the acceptance edge; writeback beats load on the same register.
      run_instr(4'd8, 2'd2, 2'd1, 2'd0, 1, 2'd1, 4'h9, 0, 0, 0, e);
      force_en = 1'b1; force_val = 5'h07;
      run_instr(4'd8, 2'd0, 2'd1, 2'd2, 0, 0, 0, 1, 2'd0, 4'hF, e);
      chk("prio_r0", dut.u_rf.regs[0], 7);
      run_instr(4'd8, 2'd0, 2'd1, 2'd2, 0, 0, 0, 1, 2'd3, 4'hA, e);
      chk("par_r3", dut.u_rf.regs[3], 4'hA);
      force_en = 1'b0;

      // Reset during EXEC abandons the instruction.
      wait_ready();
      bus.in_instr_valid = 1'b1; bus.in_instr = {4'd8, 2'd0, 2'd1, 2'd2};
      @(posedge in_clk); #1;
      bus.in_instr_valid = 1'b0;
      chk("rx_exec_fun", bus.out_fun, 8);
      #2 in_rst = 1'b1;
      #1;
      chk("rx_ready", bus.out_instr_ready, 1);
      chk("rx_outs", {bus.out_a, bus.out_b, bus.out_fun, bus.out_done, bus.out_err}, 0);
      for (int i = 0; i < 4; i++) reg_m[i] = 4'd0;
      fz_m = 1'b0; fc_m = 1'b0;
      check_regs();
      check_flags();
      @(posedge in_clk); #1;
      chk("rx_no_done", bus.out_done, 0);
      in_rst = 1'b0;
      run_instr(4'd1, 2'd2, 2'd1, 2'd1, 1, 2'd1, 4'h6, 0, 0, 0, e);

      // Table vectors.
      for (int i = 0; i < 10; i++) begin
         load(vt[i].rs1, vt[i].a);
         load(vt[i].rs2, vt[i].b);
         run_instr(vt[i].fun, vt[i].rd, vt[i].rs1, vt[i].rs2, 0, 0, 0, 0, 0, 0, e);
         chk($sformatf("tbl%0d_res", i), dut.u_rf.regs[vt[i].rd], vt[i].exp_res);
         chk($sformatf("tbl%0d_err", i), e, vt[i].exp_err);
`ifdef ALU_SEQ_FLAGS_EN
         if (!vt[i].exp_err) chk($sformatf("tbl%0d_c", i), bus.out_cflag, vt[i].exp_c);
`endif
      end

      // Randomised instructions with loads on both edges.
      for (int i = 0; i < 80; i++) begin
         run_instr(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 2'($urandom), 4'($urandom),
                   1'($urandom), 2'($urandom), 4'($urandom), e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
